// File: rtl/enc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | enc_pkg                                                              |
// | Shared constants, per-channel action encoding and width helper.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package enc_pkg;

  localparam int C_DIV_DEFAULT        = 100;
  localparam int C_STABLE_CNT_DEFAULT = 4;

  // What a channel does with its stability counter on a given cycle
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_CLEAR  = 2'd1,
    ACT_COUNT  = 2'd2,
    ACT_ACCEPT = 2'd3
  } ch_act_e;

  function automatic int clog2(input int unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_debounce_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | enc_debounce_ch                                                      |
// | One input channel: 2-flop synchronizer, stability counter, edges.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module enc_debounce_ch
  import enc_pkg::*;
#(
  parameter int STABLE_CNT = C_STABLE_CNT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int            CW     = clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_CNT - 1);

  logic          meta_q;
  logic          sync_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          dout_q;
  logic          dout_d;
  logic          rise_q;
  logic          rise_d;
  logic          fall_q;
  logic          fall_d;
  ch_act_e       w_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  // A sample matching the current output restarts qualification
  always_comb begin
    w_act = ACT_HOLD;
    if (tick) begin
      if (sync_q == dout_q) begin
        w_act = ACT_CLEAR;
      end else if (cnt_q == C_LAST) begin
        w_act = ACT_ACCEPT;
      end else begin
        w_act = ACT_COUNT;
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    case (w_act)
      ACT_CLEAR: begin
        cnt_d = '0;
      end
      ACT_COUNT: begin
        cnt_d = cnt_q + 1'b1;
      end
      ACT_ACCEPT: begin
        cnt_d  = '0;
        dout_d = sync_q;
        rise_d = sync_q;
        fall_d = ~sync_q;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule
`default_nettype wire

// File: rtl/enc_debounce_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | enc_debounce_multi                                                   |
// | Multi-channel debouncer: shared sample prescaler + per-channel cores.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module enc_debounce_multi
  import enc_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int DIV        = C_DIV_DEFAULT,
  parameter int STABLE_CNT = C_STABLE_CNT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] dout,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            tick
);

  localparam int            PW        = (DIV > 1) ? clog2(DIV) : 1;
  localparam logic [PW-1:0] C_PS_LAST = PW'(DIV - 1);

  logic [PW-1:0] ps_q;
  logic [PW-1:0] ps_d;
  logic          w_wrap;
  logic          w_tick;

  // Gating with rst keeps tick low during reset even when DIV=1
  always_comb begin
    w_wrap = (ps_q == C_PS_LAST);
    w_tick = en && w_wrap && !rst;
    ps_d   = ps_q;
    if (en) begin
      ps_d = w_wrap ? '0 : ps_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  assign tick = w_tick;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      enc_debounce_ch #(
        .STABLE_CNT(STABLE_CNT)
      ) u_ch (
        .clk (clk),
        .rst (rst),
        .tick(w_tick),
        .din (din[i]),
        .dout(dout[i]),
        .rise(rise[i]),
        .fall(fall[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/enc_debounce_multi.md
ENC_DEBOUNCE_MULTI -- requirements
Module: enc_debounce_multi

Interface
REQ-001 Parameter N_CH, default 2: number of independent input channels, legal range 1 to 32.
REQ-002 Parameter DIV, default 100: clk cycles per sample tick, legal range 1 to 65535.
REQ-003 Parameter STABLE_CNT, default 4: consecutive ticks a new level must persist before acceptance, legal range 1 to 255.
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port en, input, 1: when 1, sampling runs; when 0, prescaler and all channel counters hold.
REQ-007 Port din, input, N_CH: raw asynchronous inputs (encoder A/B, push-buttons).
REQ-008 Port dout, output, N_CH: debounced levels.
REQ-009 Port rise, output, N_CH: one-clk pulse when dout[i] goes 0->1.
REQ-010 Port fall, output, N_CH: one-clk pulse when dout[i] goes 1->0.
REQ-011 Port tick, output, 1: one-clk strobe marking each sample instant.

Function
REQ-012 Each din[i] SHALL pass through a 2-flop synchronizer; sync[i] is the second-stage output.
REQ-013 Prescaler SHALL count 0..DIV-1 while en=1, assert tick for exactly the one cycle where count=DIV-1, then wrap to 0; with DIV=1, tick is high every en=1 cycle.
REQ-014 With en=0, the prescaler SHALL hold its value and tick SHALL be 0.
REQ-015 Each channel SHALL have a stability counter of width clog2(STABLE_CNT+1), updated only on tick cycles.
REQ-016 On tick, if sync[i] equals dout[i], the counter SHALL clear to 0 (a bounce restarts qualification).
REQ-017 On tick, if sync[i] differs from dout[i] and counter equals STABLE_CNT-1, dout[i] SHALL take sync[i] at that clock edge and the counter SHALL clear to 0.
REQ-018 On tick, if sync[i] differs from dout[i] and counter is below STABLE_CNT-1, the counter SHALL increment by 1; it SHALL never exceed STABLE_CNT-1.
REQ-019 rise[i]/fall[i] SHALL be registered, asserted in the same cycle dout[i] shows its new value, for exactly one clk cycle, and never both high.
REQ-020 Channels SHALL be fully independent; simultaneous changes on several channels SHALL update in the same cycle.
REQ-021 Latency: a clean din edge SHALL appear on dout after 2 clk cycles (synchronizer) plus the STABLE_CNT-th tick that samples the new level; worst case 2 + STABLE_CNT*DIV cycles.

Reset
REQ-022 While rst=1, sync flops, prescaler, counters, dout, rise, fall and tick SHALL be 0, independent of clk.
REQ-023 Reset asserted mid-qualification SHALL discard the partial count; after release qualification restarts from 0 against dout=0.
REQ-024 If din[i]=1 at reset release, dout[i] SHALL rise only after full qualification, with a rise[i] pulse.

Structure
REQ-025 Package enc_pkg SHALL hold the clog2 helper and the default constants for DIV and STABLE_CNT.
REQ-026 The prescaler SHALL be in the top module, shared by all channels.
REQ-027 The per-channel synchronizer, counter and edge logic SHALL be sub-module enc_debounce_ch, instantiated N_CH times in a generate loop.

Verification (N_CH=2, DIV=4, STABLE_CNT=3 unless noted)
REQ-028 Hold rst=1 with din=2'b11 for 20 cycles -> dout, rise, fall, tick all 0; after release, dout=2'b11 within 2+12 cycles, each channel with one rise pulse.
REQ-029 Clean step on din[0] 0->1 -> dout[0]=1 on the third tick after sync[0]=1, rise[0] high for 1 cycle, fall[0] stays 0, dout[1] unchanged.
REQ-030 Bounce: din[1] high for 2 ticks, low for 1 tick, then high for 3 ticks -> no dout[1] change until the end of the 3-tick run, exactly one rise[1] pulse.
REQ-031 din=2'b00->2'b11 in one cycle -> both dout bits and both rise bits assert in the same cycle.
REQ-032 en=0 for 10 cycles after 1 qualifying tick -> tick stays 0 and dout holds; after en=1 returns, dout changes after 2 more ticks.
REQ-033 Assert rst asynchronously between edges after 2 qualifying ticks -> outputs 0 immediately; after release a full 3 ticks are required (DIV=1, STABLE_CNT=1 repeated: update on the first differing cycle).
